biphase_decoder: RTL

Receive-side counterpart of the biphase-mark encoder: it takes the raw biphase-mark line from the optical receiver front end and oversamples it on the system clock. It recovers bit boundaries from transition spacing and emits decoded logical bits as single-cycle strobes. It sits between the photodiode comparator input pin and the receive framing/deserializer logic.

---
 rtl/biphase_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/biphase_decoder.sv
// Biphase-mark receive decoder: oversamples the line, classifies
// edge spacing and emits decoded bits as one-cycle strobes.
module biphase_decoder #(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic biphase_in,
  output logic data_out,
  output logic data_valid,
  output logic locked,
  output logic error_out
);

  localparam int H   = CYCLES_PER_BIT / 2;
  localparam int SAT = (5 * H + 1) / 2;
  localparam int CW  = $clog2(SAT + 1);
  localparam logic [CW-1:0] SATV = CW'(SAT);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    BOUNDARY,
    MID
  } state_t;

  state_t state, state_n;

  logic s1, s2, s3;
  logic edge_q;
  logic [CW-1:0] cnt;
  logic gl, sh, timeout;
  logic dv_n, err_n, dout_n, lock_n;

  // Thresholds compared at 2x so odd H keeps exact half-cycle bounds
  assign gl = (2 * int'(cnt)) < H;
  assign sh = !gl && ((2 * int'(cnt)) < 3 * H);
  assign timeout = (cnt == SATV) && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      edge_q <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= biphase_in;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 ^ s3;
      if (edge_q)
        cnt <= CW'(1);
      else if (cnt < SATV)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    lock_n  = locked;
    dout_n  = data_out;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    if (timeout) begin
      // An edge landing on the saturation cycle restarts alignment
      state_n = edge_q ? ALIGN : IDLE;
      lock_n  = 1'b0;
      err_n   = locked;
    end else if (edge_q) begin
      unique case (state)
        IDLE: state_n = ALIGN;
        ALIGN: begin
          if (!gl && !sh) begin
            dv_n    = 1'b1;
            dout_n  = 1'b0;
            lock_n  = 1'b1;
            state_n = BOUNDARY;
          end
        end
        BOUNDARY: begin
          unique case (1'b1)
            gl: begin
              err_n   = 1'b1;
              lock_n  = 1'b0;
              state_n = ALIGN;
            end
            sh: state_n = MID;
            default: begin
              dv_n   = 1'b1;
              dout_n = 1'b0;
            end
          endcase
        end
        MID: begin
          if (sh) begin
            dv_n    = 1'b1;
            dout_n  = 1'b1;
            state_n = BOUNDARY;
          end else begin
            err_n   = 1'b1;
            lock_n  = 1'b0;
            state_n = ALIGN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state      <= state_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      locked     <= lock_n;
      error_out  <= err_n;
    end
  end

endmodule
